pipe_reg_elastic: RTL
=====================

// Module: pipe_reg_elastic
// PURPOSE
//  Parametrised elastic pipeline register: DEPTH stages of WIDTH-bit data, each with a valid bit.
//  Stalls via a valid/ready handshake and collapses bubbles. A flush kills all in-flight entries.
//  Drop-in between datapath stages where a fixed stage register cannot absorb backpressure.
// PARAMETERS
//  WIDTH     8  data width in bits (>=1)
//  DEPTH     2  number of register stages (>=1); latency in cycles when unstalled
//  CLR_DATA  1  1: reset and flush zero every stage's data; 0: flush clears valids only, data held
// PORTS
//  clk        in   1                    clock, all state updates on rising edge
//  reset      in   1                    reset, synchronous, active-high
//  flush      in   1                    sync clear of all stages, active-high
//  in_valid   in   1                    upstream presents in_data
//  in_ready   out  1                    block accepts in_data this cycle
//  in_data    in   WIDTH                upstream data
//  out_valid  out  1                    out_data holds a valid entry
//  out_ready  in   1                    downstream accepts out_data this cycle
//  out_data   out  WIDTH                data of last stage
//  occupancy  out  $clog2(DEPTH+1)      number of valid stages, 0..DEPTH
// BEHAVIOUR
//  - State: v[i], d[i] for i=0..DEPTH-1. Stage DEPTH-1 drives out_valid=v[DEPTH-1], out_data=d[DEPTH-1].
//  - Stage ready (combinational): rdy[DEPTH-1] = !v[DEPTH-1] | out_ready; rdy[i] = !v[i] | rdy[i+1].
//  - in_ready = rdy[0] & !flush. Input handshake = in_valid & in_ready. Output handshake = out_valid & out_ready.
//  - Priority per edge: reset > flush > normal advance.
//  - reset: all v=0, all d=0 (regardless of CLR_DATA). Outputs after reset: out_valid=0, out_data=0,
//    occupancy=0, in_ready=1 (when flush=0).
//  - flush (reset=0): all v=0 next cycle; d zeroed if CLR_DATA=1, else held. in_valid ignored
//    (in_ready=0, so no handshake). An output handshake in the flush cycle counts as delivered.
//  - Normal: for each i with rdy[i]=1: v[i] <= upstream valid (in_valid for i=0, v[i-1] otherwise);
//    d[i] <= upstream data only when the upstream valid is 1; else d[i] held.
//    Stages with rdy[i]=0 hold v and d.
//  - Latency: entry accepted at edge N appears on out_valid after edge N+DEPTH-1 when never stalled.
//    Throughput: 1 entry per cycle while out_ready=1.
//  - Bubble collapse: an empty stage accepts from upstream even while the output is stalled.
//    Full-stall capacity = DEPTH.
//  - Ordering strictly FIFO. No entry is duplicated or dropped except by flush or reset.
//  - in_ready depends combinationally on out_ready (ready chain). out_valid/out_data are registered.
//  - occupancy = popcount(v), combinational from registered v.
//  - Reset or flush mid-stall: all entries discarded, in_ready returns to 1 the next cycle.
// TESTING (WIDTH=8, DEPTH=3, CLR_DATA=1 unless noted)
//  1 Reset: hold reset 2 cycles with in_valid=1, in_data=FF -> out_valid=0, out_data=00, occupancy=0;
//    after release, in_ready=1.
//  2 Stream: out_ready=1; push 11,22,33 on consecutive edges -> out_data 11,22,33 on consecutive cycles.
//    11 is valid after the 3rd edge; in_ready stays 1 throughout.
//  3 Backpressure: out_ready=0; push A1..A4 -> A1..A3 accepted, in_ready=0 with A4 pending, occupancy=3;
//    raise out_ready -> A1,A2,A3,A4 delivered in order, none lost or duplicated.
//  4 Bubble collapse: out_ready=0; push B1, idle 1 cycle, push B2, B3 -> all three accepted, occupancy=3.
//    Order B1,B2,B3 at output.
//  5 Flush: occupancy=2 (C1,C2); flush=1 with in_valid=1, in_data=55 -> in_ready=0 that cycle;
//    next cycle occupancy=0, out_valid=0, out_data=00; 55 never emerges.
//    With CLR_DATA=0, out_data still shows the held value.
//  6 Simultaneous: reset=1 and flush=1 in the same cycle with out_ready=0 at full occupancy
//    -> reset result (all zero).
//    Then flush concurrent with an output handshake -> that entry counts as delivered, rest cleared.

Source files
------------

// File: rtl/pipe_reg_elastic.sv
// Elastic pipeline register: DEPTH valid/data stages with a ready chain.
// Empty stages fill even while the output stalls, so bubbles collapse.
module pipe_reg_elastic #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 2,
    parameter int CLR_DATA = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH-1:0] rdy;
    logic [DEPTH-1:0] uv;
    logic [WIDTH-1:0] ud [DEPTH];

    // A stage is ready if it or any stage downstream is empty,
    // or the output is being drained.
    always_comb begin
        logic r;
        rdy = '0;
        r   = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            r      = r | ~v[i];
            rdy[i] = r;
        end
    end

    always_comb begin
        uv    = '0;
        uv[0] = in_valid;
        ud[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            uv[i] = v[i-1];
            ud[i] = d[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v <= '0;
            for (int i = 0; i < DEPTH; i++) d[i] <= '0;
        end else if (flush) begin
            v <= '0;
            if (CLR_DATA != 0) begin
                for (int i = 0; i < DEPTH; i++) d[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rdy[i]) begin
                    v[i] <= uv[i];
                    if (uv[i]) d[i] <= ud[i];
                end
            end
        end
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OW'(v[i]);
        end
    end

    assign in_ready  = rdy[0] & ~flush;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

endmodule
